mem_sram_ctrl: RTL and testbench

Single-port controller for an external asynchronous SRAM, sitting directly downstream of the prioritized memory arbiter. It consumes the arbiter's `slave_req` stream, runs one SRAM read or write cycle per request with parameterized wait states, and returns exactly one response per request, in order, on the arbiter's `slave_resp` stream. Only one transaction is outstanding at any time; the arbiter's index queue therefore never holds more than one entry on this path.

---
 rtl/mem_sram_ctrl_pkg.sv | 24 ++
 rtl/mem_sram_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared memory bus types: request/response bundles
// exchanged between cores, the arbiter and memory slaves.
package mem_sram_ctrl_pkg;

  localparam int MEM_AW  = 32;
  localparam int MEM_DW  = 32;
  localparam int MEM_BEW = MEM_DW / 8;

  typedef struct packed {
    logic [MEM_AW-1:0]  addr;
    logic               we;
    logic [MEM_BEW-1:0] be;
    logic [MEM_DW-1:0]  wdata;
  } mreq_t;

  typedef struct packed {
    logic [MEM_DW-1:0] rdata;
  } mresp_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// Async SRAM controller: one read/write cycle per request, one
// response per request. Ports: clk, rst (async, active-low),
// req_* (valid/ready/bits in), resp_* (valid/ready/bits out),
// sram_* pins (addr, dq_o/dq_oe/dq_i, ce_n/oe_n/we_n, be_n).
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int READ_WAIT       = 2,
  parameter int WRITE_WAIT      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  mreq_t                      req_bits,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output mresp_t                     resp_bits,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DW-1:0]          sram_dq_o,
  output logic                       sram_dq_oe,
  input  logic [MEM_DW-1:0]          sram_dq_i,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [MEM_BEW-1:0]         sram_be_n
);

  localparam int CW = $clog2(imax(READ_WAIT, WRITE_WAIT) + 2);
  localparam int SAW = SRAM_ADDR_WIDTH;

  if (DATA_WIDTH != MEM_DW || ADDR_WIDTH != MEM_AW ||
      SAW + 2 > ADDR_WIDTH || READ_WAIT < 0 ||
      WRITE_WAIT < 1) begin : g_bad_param
    $error("mem_sram_ctrl: unsupported parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAW-1:0]      addr_q, addr_d;
  logic [MEM_DW-1:0]   dq_o_q, dq_o_d;
  logic [MEM_DW-1:0]   rdata_q, rdata_d;
  logic [MEM_BEW-1:0]  be_n_q, be_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                fire;
  logic                unused_ok;

  // Upper address bits alias; the byte offset is meaningless.
  assign unused_ok = ^req_bits.addr;

  assign req_ready  = rst & (state_q == S_IDLE);
  assign fire       = req_valid & req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_bits  = '{rdata: rdata_q};

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      rdata_q <= '0;
      be_n_q  <= '1;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      rdata_q <= rdata_d;
      be_n_q  <= be_n_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (req_bits.we) begin
            state_d = S_WR_SETUP;
            cnt_d   = '0;
          end else begin
            state_d = S_READ;
            cnt_d   = CW'(READ_WAIT);
          end
        end
      end
      S_READ: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = CW'(WRITE_WAIT - 1);
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) state_d = S_WR_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WR_HOLD: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are computed for the state being entered so
  // every SRAM output comes straight from a flop.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = '1;
    dq_oe_d = 1'b0;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    rdata_d = rdata_q;
    unique case (state_d)
      S_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      S_WR_SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = ~req_bits.be;
      end
      S_WR_PULSE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = be_n_q;
        we_n_d  = 1'b0;
      end
      S_WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        be_n_d  = be_n_q;
      end
      default: ;
    endcase
    // Clearing on accept gives writes their zero response.
    if (fire) begin
      addr_d  = req_bits.addr[SAW+1:2];
      rdata_d = '0;
      if (req_bits.we) dq_o_d = req_bits.wdata;
    end
    if (state_q == S_READ && state_d == S_RESP)
      rdata_d = sram_dq_i;
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: default instance with an SRAM model
// plus a READ_WAIT=0/WRITE_WAIT=1 instance for latency.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  mreq_t       req_bits = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  mresp_t      resp_bits;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  logic        f_req_valid = 1'b0;
  logic        f_req_ready;
  mreq_t       f_req_bits = '0;
  logic        f_resp_valid;
  logic        f_resp_ready = 1'b1;
  mresp_t      f_resp_bits;
  logic [19:0] f_addr;
  logic [31:0] f_dq_o;
  logic        f_dq_oe;
  logic [31:0] f_dq_i;
  logic        f_ce_n, f_oe_n, f_we_n;
  logic [3:0]  f_be_n;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[256];

  mem_sram_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits(req_bits),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bits(resp_bits),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  mem_sram_ctrl #(.READ_WAIT(0), .WRITE_WAIT(1)) u_fast (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_bits(f_req_bits),
    .resp_valid(f_resp_valid), .resp_ready(f_resp_ready),
    .resp_bits(f_resp_bits),
    .sram_addr(f_addr), .sram_dq_o(f_dq_o),
    .sram_dq_oe(f_dq_oe), .sram_dq_i(f_dq_i),
    .sram_ce_n(f_ce_n), .sram_oe_n(f_oe_n),
    .sram_we_n(f_we_n), .sram_be_n(f_be_n)
  );

  // Async SRAM model; tristate resolved here.
  assign sram_dq_i = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 &&
                      sram_dq_oe !== 1'b1) ? mem[sram_addr[7:0]] : 32'h0;
  assign f_dq_i = (f_ce_n === 1'b0 && f_oe_n === 1'b0)
                  ? {12'hCAF, f_addr} : 32'h0;

  always @(negedge clk) begin
    if (rst && sram_ce_n === 1'b0 && sram_we_n === 1'b0 &&
        sram_dq_oe === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          mem[sram_addr[7:0]][b*8 +: 8] = sram_dq_o[b*8 +: 8];
    end
  end

  // Scoreboard: pop in order on every response handshake.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (rst && resp_valid && resp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%h", resp_bits.rdata);
      end else begin
        e = exp_q.pop_front();
        if (resp_bits.rdata !== e) begin
          failures++;
          $display("FAIL sb_rdata got=%h exp=%h", resp_bits.rdata, e);
        end
      end
    end
  end

  task automatic issue(input mreq_t r, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_timeout ready=%b exp=1", req_ready);
    end
    req_bits  = r;
    req_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_hs got=%b exp=00", {req_ready, resp_valid});
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}
        !== 8'b1111_1110) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=11111110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe});
    end
    checks++;
    if ({sram_addr, sram_dq_o, resp_bits.rdata} !== 84'h0) begin
      failures++;
      $display("FAIL rst_data addr=%h dq=%h rd=%h exp=0",
               sram_addr, sram_dq_o, resp_bits.rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_release ready=%b exp=1", req_ready);
    end
  endtask

  task automatic test_read();
    mreq_t r;
    r = '{addr: 32'h0000_0010, we: 1'b0, be: 4'hF, wdata: '0};
    issue(r, 32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (sram_addr !== 20'd4) begin
          failures++;
          $display("FAIL rd_addr got=%h exp=4", sram_addr);
        end
      end
      checks++;
      if ({sram_oe_n, resp_valid} !== ((k < 4) ? 2'b00 : 2'b11)) begin
        failures++;
        $display("FAIL rd_cyc%0d oe_n,valid got=%b", k,
                 {sram_oe_n, resp_valid});
      end
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rd_drain left=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_write();
    mreq_t r;
    mem[2] = 32'hAABB_CCDD;
    r = '{addr: 32'h0000_0008, we: 1'b1, be: 4'b0101,
          wdata: 32'h1234_5678};
    issue(r, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({sram_we_n, sram_dq_oe, resp_valid} !==
          {~(k == 2 || k == 3), k <= 4, k == 5}) begin
        failures++;
        $display("FAIL wr_cyc%0d we_n,oe,valid got=%b", k,
                 {sram_we_n, sram_dq_oe, resp_valid});
      end
      if (k == 1) begin
        checks++;
        if ({sram_be_n, sram_addr, sram_dq_o} !==
            {4'b1010, 20'd2, 32'h1234_5678}) begin
          failures++;
          $display("FAIL wr_setup be_n=%b addr=%h dq=%h",
                   sram_be_n, sram_addr, sram_dq_o);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (mem[2] !== 32'hAA34_CC78) begin
      failures++;
      $display("FAIL wr_mem got=%h exp=aa34cc78", mem[2]);
    end
  endtask

  task automatic test_be_zero();
    mreq_t r;
    mem[1] = 32'h1111_1111;
    r = '{addr: 32'h0000_0004, we: 1'b1, be: 4'b0000,
          wdata: 32'hFFFF_FFFF};
    issue(r, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({sram_we_n, sram_be_n} !== 5'b0_1111) begin
      failures++;
      $display("FAIL be0_pulse got=%b exp=01111",
               {sram_we_n, sram_be_n});
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || mem[1] !== 32'h1111_1111) begin
      failures++;
      $display("FAIL be0_mem left=%0d got=%h exp=11111111",
               exp_q.size(), mem[1]);
    end
  endtask

  task automatic test_backpressure();
    mreq_t r;
    mem[7] = 32'h0BAD_F00D;
    r = '{addr: 32'hFFF0_001C, we: 1'b0, be: 4'hF, wdata: '0};
    resp_ready = 1'b0;
    issue(r, 32'h0BAD_F00D);
    @(negedge clk);
    checks++;
    if (sram_addr !== 20'hC0007) begin
      failures++;
      $display("FAIL bp_alias got=%h exp=c0007", sram_addr);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({resp_valid, resp_bits.rdata, req_ready, sram_ce_n,
           sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !==
          {1'b1, 32'h0BAD_F00D, 1'b0, 3'b111, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d v=%b rd=%h rdy=%b ctl=%b", k,
                 resp_valid, resp_bits.rdata, req_ready,
                 {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
                  sram_dq_oe});
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain left=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    mreq_t rq[2];
    logic [31:0] ex[2];
    int fc[2];
    int cyc, idx;
    rq[0] = '{addr: 32'h10, we: 1'b0, be: 4'hF, wdata: '0};
    rq[1] = '{addr: 32'h08, we: 1'b0, be: 4'hF, wdata: '0};
    ex[0] = 32'hDEAD_BEEF;
    ex[1] = 32'hAA34_CC78;
    fc[0] = 0;
    fc[1] = 0;
    cyc = 0;
    idx = 0;
    @(negedge clk);
    req_bits  = rq[0];
    req_valid = 1'b1;
    while (idx < 2 && cyc < 60) begin
      if (req_ready === 1'b1) begin
        exp_q.push_back(ex[idx]);
        fc[idx] = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 2) req_bits = rq[idx];
        else         req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if (idx != 2 || fc[1] - fc[0] != 5) begin
      failures++;
      $display("FAIL b2b_spacing fired=%0d gap=%0d exp=5", idx,
               fc[1] - fc[0]);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain left=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    mreq_t r;
    r = '{addr: 32'h20, we: 1'b1, be: 4'hF, wdata: 32'h5555_AAAA};
    issue(r, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL mrst_pulse we_n=%b exp=0", sram_we_n);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sram_we_n, sram_dq_oe, resp_valid, sram_ce_n,
         sram_be_n, req_ready} !== 9'b1_0_0_1_1111_0) begin
      failures++;
      $display("FAIL mrst_async got=%b exp=100111110",
               {sram_we_n, sram_dq_oe, resp_valid, sram_ce_n,
                sram_be_n, req_ready});
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL mrst_after got=%b exp=10",
               {req_ready, resp_valid});
    end
  endtask

  task automatic test_fast_latency();
    @(negedge clk);
    f_req_bits  = '{addr: 32'h14, we: 1'b0, be: 4'hF, wdata: '0};
    f_req_valid = 1'b1;
    @(posedge clk);
    #1 f_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({f_oe_n, f_resp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL fast_rd_c1 got=%b exp=00", {f_oe_n, f_resp_valid});
    end
    @(negedge clk);
    checks++;
    if ({f_resp_valid, f_resp_bits.rdata} !== {1'b1, 32'hCAF0_0005}) begin
      failures++;
      $display("FAIL fast_rd_c2 v=%b rd=%h exp=1 caf00005",
               f_resp_valid, f_resp_bits.rdata);
    end
    @(negedge clk);
    f_req_bits  = '{addr: 32'h18, we: 1'b1, be: 4'hF, wdata: 32'h1};
    f_req_valid = 1'b1;
    @(posedge clk);
    #1 f_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({f_we_n, f_resp_valid} !== {k != 2, k == 4}) begin
        failures++;
        $display("FAIL fast_wr_c%0d we_n,valid got=%b", k,
                 {f_we_n, f_resp_valid});
      end
    end
    checks++;
    if (f_resp_bits.rdata !== 32'h0) begin
      failures++;
      $display("FAIL fast_wr_rdata got=%h exp=0", f_resp_bits.rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_be_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    test_fast_latency();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
